// File: rtl/sargantana_itag_ctrl_pkg.sv
// Shared I-cache tag-controller types: geometry, FSM states, way one-hot type
// and a lowest-set-bit helper used for hit and victim selection.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY   = 4;
  localparam int TAG_DEPTH      = 64;
  localparam int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH);
  localparam int TAG_WIDHT      = 20;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    REFILL_WAIT,
    FLUSH
  } itag_ctrl_state_e;

  typedef logic [ICACHE_N_WAY-1:0] way_onehot_t;

  function automatic way_onehot_t lowest_onehot(input way_onehot_t v);
    way_onehot_t r;
    r = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// Tag-memory port bundle between the tag controller (master) and
// sargantana_itag_memory_sram (slave).
interface sargantana_itag_ctrl_if;
  import sargantana_icache_pkg::*;

  way_onehot_t                          tm_req_o;
  logic                                 tm_we_o;
  logic                                 tm_vbit_o;
  logic                                 tm_flush_o;
  logic [TAG_WIDHT-1:0]                 tm_data_o;
  logic [TAG_ADDR_WIDHT-1:0]            tm_addr_o;
  logic [ICACHE_N_WAY*TAG_WIDHT-1:0]    tm_tag_way_i;
  way_onehot_t                          tm_vbit_i;

  modport master (
    output tm_req_o, tm_we_o, tm_vbit_o, tm_flush_o, tm_data_o, tm_addr_o,
    input  tm_tag_way_i, tm_vbit_i
  );

  modport slave (
    input  tm_req_o, tm_we_o, tm_vbit_o, tm_flush_o, tm_data_o, tm_addr_o,
    output tm_tag_way_i, tm_vbit_i
  );

endinterface

// File: rtl/sargantana_itag_ctrl_plru.sv
// Per-set tree pseudo-LRU for the I-cache tags; only built when
// ITAG_CTRL_PLRU_EN is defined. A node bit of 0 points the victim walk left.
`ifdef ITAG_CTRL_PLRU_EN
module sargantana_itag_plru
  import sargantana_icache_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [TAG_ADDR_WIDHT-1:0] rd_idx_i,
  output way_onehot_t               victim_o,
  input  logic                      upd_i,
  input  logic [TAG_ADDR_WIDHT-1:0] upd_idx_i,
  input  way_onehot_t               upd_way_i
);

  localparam int LVL   = $clog2(ICACHE_N_WAY);
  localparam int NODES = ICACHE_N_WAY - 1;

  logic [NODES-1:0] bits_q [TAG_DEPTH];
  logic [NODES-1:0] rd_bits;
  logic [NODES-1:0] upd_bits_d;

  // A way is the victim when every node on its root-to-leaf path points at it.
  always_comb begin
    rd_bits  = bits_q[rd_idx_i];
    victim_o = '1;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      for (int l = 0; l < LVL; l++) begin
        if (rd_bits[(1 << l) - 1 + (w >> (LVL - l))] != 1'((w >> (LVL - 1 - l)) & 1))
          victim_o[w] = 1'b0;
      end
    end
  end

  always_comb begin
    upd_bits_d = bits_q[upd_idx_i];
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      if (upd_way_i[w]) begin
        for (int l = 0; l < LVL; l++)
          upd_bits_d[(1 << l) - 1 + (w >> (LVL - l))] = ~1'((w >> (LVL - 1 - l)) & 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < TAG_DEPTH; s++) bits_q[s] <= '0;
    end else if (upd_i) begin
      bits_q[upd_idx_i] <= upd_bits_d;
    end
  end

endmodule
`endif

// File: rtl/sargantana_itag_ctrl.sv
// I-cache tag sequencer: lookup/compare, victim selection, refill tag write and
// serialised flush. ITAG_CTRL_PLRU_EN selects tree PLRU instead of round-robin.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      lookup_valid_i,
  output logic                      lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0] lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]      lookup_tag_i,
  output logic                      resp_valid_o,
  output logic                      resp_hit_o,
  output way_onehot_t               resp_way_o,
  input  logic                      refill_valid_i,
  output logic                      refill_done_o,
  input  logic                      flush_i,
  sargantana_itag_ctrl_if.master    tm
);

  itag_ctrl_state_e          state_q, state_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      drop_q, drop_d;
  logic [TAG_ADDR_WIDHT-1:0] idx_q;
  logic [TAG_WIDHT-1:0]      tag_q;
  way_onehot_t               victim_q;

  way_onehot_t hit, hit_way, miss_way, repl_way;
  logic        any_hit, flush_req, accept, tag_write;

  always_comb begin
    hit = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++)
      hit[w] = tm.tm_vbit_i[w] & (tm.tm_tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == tag_q);
  end

  // Invalid ways are filled first; the policy only decides once the set is full.
  assign any_hit  = |hit;
  assign hit_way  = lowest_onehot(hit);
  assign miss_way = (&tm.tm_vbit_i) ? repl_way : lowest_onehot(~tm.tm_vbit_i);

  assign flush_req      = flush_i | flush_pend_q;
  assign lookup_ready_o = (state_q == IDLE) & ~flush_req;
  assign accept         = lookup_valid_i & lookup_ready_o;
  assign tag_write      = (state_q == REFILL_WAIT) & refill_valid_i & ~drop_q & ~flush_req;

`ifdef ITAG_CTRL_PLRU_EN
  logic        plru_upd;
  way_onehot_t plru_upd_way;

  assign plru_upd     = tag_write | ((state_q == COMPARE) & any_hit);
  assign plru_upd_way = tag_write ? victim_q : hit_way;

  sargantana_itag_plru u_plru (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .rd_idx_i  (idx_q),
    .victim_o  (repl_way),
    .upd_i     (plru_upd),
    .upd_idx_i (idx_q),
    .upd_way_i (plru_upd_way)
  );
`else
  way_onehot_t rr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        rr_q <= {{(ICACHE_N_WAY-1){1'b0}}, 1'b1};
    else if (tag_write) rr_q <= {rr_q[ICACHE_N_WAY-2:0], rr_q[ICACHE_N_WAY-1]};
  end

  assign repl_way = rr_q;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      drop_q       <= 1'b0;
      idx_q        <= '0;
      tag_q        <= '0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      drop_q       <= drop_d;
      if (accept) begin
        idx_q <= lookup_idx_i;
        tag_q <= lookup_tag_i;
      end
      if ((state_q == COMPARE) && !any_hit) victim_q <= miss_way;
    end
  end

  // A flush during REFILL_WAIT marks the outstanding refill to be consumed without a tag write.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        if (flush_req)           state_d = FLUSH;
        else if (lookup_valid_i) state_d = COMPARE;
      end
      COMPARE: begin
        if (flush_i) flush_pend_d = 1'b1;
        state_d = any_hit ? IDLE : REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (flush_req) begin
          flush_pend_d = 1'b0;
          drop_d       = 1'b1;
        end
        if (refill_valid_i) begin
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid_o  = 1'b0;
    resp_hit_o    = 1'b0;
    resp_way_o    = '0;
    refill_done_o = 1'b0;
    tm.tm_req_o   = '0;
    tm.tm_we_o    = 1'b0;
    tm.tm_vbit_o  = 1'b0;
    tm.tm_flush_o = 1'b0;
    tm.tm_data_o  = '0;
    tm.tm_addr_o  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tm.tm_req_o  = '1;
          tm.tm_addr_o = lookup_idx_i;
        end
      end
      COMPARE: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = any_hit;
        resp_way_o   = any_hit ? hit_way : miss_way;
      end
      REFILL_WAIT: begin
        tm.tm_flush_o = flush_req;
        refill_done_o = refill_valid_i;
        if (tag_write) begin
          tm.tm_req_o   = victim_q;
          tm.tm_we_o    = 1'b1;
          tm.tm_vbit_o  = 1'b1;
          tm.tm_data_o  = tag_q;
          tm.tm_addr_o  = idx_q;
        end
      end
      FLUSH: tm.tm_flush_o = 1'b1;
      default: ;
    endcase
  end

endmodule
